// File: rtl/mag_approx_pkg.sv
// Shared types and shift constants for the magnitude approximation pipeline.
// Set B support is controlled by the MAG_APPROX_MODE_B_EN macro.
package mag_approx_pkg;

    typedef enum logic {
        MODE_A = 1'b0,
        MODE_B = 1'b1
    } mode_e;

    localparam int SH_A_MAX  = 3;
    localparam int SH_B_MAX  = 4;
    localparam int SH_MIN    = 1;
    localparam int SH_B_MIN2 = 5;

endpackage

// File: rtl/mag_approx_coef.sv
// Combinational alpha*max + beta*min estimate from shifted operands.
// Set B terms exist only when MAG_APPROX_MODE_B_EN is defined.
module mag_approx_coef
    import mag_approx_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_max,
    input  logic [WIDTH-1:0] i_min,
    input  mode_e            i_mode,
    output logic [WIDTH:0]   o_sum
);

    logic [WIDTH:0] w_max;
    logic [WIDTH:0] w_min;
    logic [WIDTH:0] w_sum_a;

    assign w_max = {1'b0, i_max};
    assign w_min = {1'b0, i_min};

    // One extra bit is enough: the result never exceeds 1.5 * max.
    assign w_sum_a = w_max - (w_max >> SH_A_MAX) + (w_min >> SH_MIN);

`ifdef MAG_APPROX_MODE_B_EN
    logic [WIDTH:0] w_sum_b;

    assign w_sum_b = w_max - (w_max >> SH_B_MAX) + (w_min >> SH_MIN)
                   - (w_min >> SH_B_MIN2);
    assign o_sum   = (i_mode == MODE_B) ? w_sum_b : w_sum_a;
`else
    logic w_unused_mode;

    assign w_unused_mode = i_mode;
    assign o_sum         = w_sum_a;
`endif

endmodule

// File: rtl/mag_approx_pipe.sv
// Three-stage valid/ready pipeline approximating sqrt(a^2+b^2) with a tag sideband.
// Define MAG_APPROX_MODE_B_EN to honour in_mode (set B); otherwise set A is used.
module mag_approx_pipe
    import mag_approx_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inp_a,
    input  logic [WIDTH-1:0] inp_b,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic [WIDTH:0]   y,
    output logic [TAG_W-1:0] y_tag,
    output logic             y_valid,
    input  logic             y_ready
);

    logic             r_s1_v;
    logic [WIDTH-1:0] r_s1_max;
    logic [WIDTH-1:0] r_s1_min;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_v;
    logic [WIDTH:0]   r_s2_sum;
    logic [WIDTH-1:0] r_s2_max;
    logic [TAG_W-1:0] r_s2_tag;

    logic             r_s3_v;
    logic [WIDTH:0]   r_s3_y;
    logic [TAG_W-1:0] r_s3_tag;

    logic             w_s1_en;
    logic             w_s2_en;
    logic             w_s3_en;
    logic             w_a_gt_b;
    logic [WIDTH-1:0] w_max;
    logic [WIDTH-1:0] w_min;
    mode_e            w_s1_mode;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_s2_max_x;
    logic [WIDTH:0]   w_y;

    // A stage may load when empty or when its content leaves this same cycle.
    assign w_s3_en  = !r_s3_v || y_ready;
    assign w_s2_en  = !r_s2_v || w_s3_en;
    assign w_s1_en  = !r_s1_v || w_s2_en;
    assign in_ready = w_s1_en;

    assign w_a_gt_b = inp_a > inp_b;
    assign w_max    = w_a_gt_b ? inp_a : inp_b;
    assign w_min    = w_a_gt_b ? inp_b : inp_a;

`ifdef MAG_APPROX_MODE_B_EN
    mode_e r_s1_mode;

    always_ff @(posedge clk) begin
        if (w_s1_en && in_valid) begin
            r_s1_mode <= mode_e'(in_mode);
        end
    end

    assign w_s1_mode = r_s1_mode;
`else
    logic w_unused_mode;

    assign w_unused_mode = in_mode;
    assign w_s1_mode     = MODE_A;
`endif

    mag_approx_coef #(
        .WIDTH (WIDTH)
    ) u_coef (
        .i_max  (r_s1_max),
        .i_min  (r_s1_min),
        .i_mode (w_s1_mode),
        .o_sum  (w_sum)
    );

    // The estimate can undershoot max for small min; floor it at max.
    assign w_s2_max_x = {1'b0, r_s2_max};
    assign w_y        = (r_s2_sum > w_s2_max_x) ? r_s2_sum : w_s2_max_x;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_v <= 1'b0;
            r_s2_v <= 1'b0;
            r_s3_v <= 1'b0;
        end else begin
            if (w_s1_en) begin
                r_s1_v <= in_valid;
            end
            if (w_s2_en) begin
                r_s2_v <= r_s1_v;
            end
            if (w_s3_en) begin
                r_s3_v <= r_s2_v;
            end
        end
    end

    // Payload registers carry no reset; they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (w_s1_en && in_valid) begin
            r_s1_max <= w_max;
            r_s1_min <= w_min;
            r_s1_tag <= in_tag;
        end
        if (w_s2_en && r_s1_v) begin
            r_s2_sum <= w_sum;
            r_s2_max <= r_s1_max;
            r_s2_tag <= r_s1_tag;
        end
        if (w_s3_en && r_s2_v) begin
            r_s3_y   <= w_y;
            r_s3_tag <= r_s2_tag;
        end
    end

    assign y       = r_s3_y;
    assign y_tag   = r_s3_tag;
    assign y_valid = r_s3_v;

endmodule

// File: doc/mag_approx_pipe.md
MAG_APPROX_PIPE -- requirements
Module: mag_approx_pipe

Interface
REQ-001 Parameter WIDTH, 32: operand width in bits (range 4..64).
REQ-002 Parameter TAG_W, 4: width of the sideband tag carried alongside each sample.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  an input sample is presented.
REQ-006 in_ready  output  1  the block accepts the sample this cycle.
REQ-007 inp_a, inp_b  input  WIDTH each  unsigned vector components.
REQ-008 in_mode  input  1  coefficient set: 0 = set A, 1 = set B.
REQ-009 in_tag  input  TAG_W  opaque sample identifier.
REQ-010 y  output  WIDTH+1  approximate magnitude sqrt(a^2+b^2).
REQ-011 y_tag  output  TAG_W  tag of the sample on y.
REQ-012 y_valid  output  1  y and y_tag are valid.
REQ-013 y_ready  input  1  the consumer accepts y this cycle.

Function
REQ-014 A transfer SHALL occur on a rising edge when valid and ready are both 1, on each side independently.
REQ-015 Pipeline: S1 register {max, min, mode, tag}, where max=(a>b)?a:b and min is the other operand; S2 register {sum, max, tag}; S3 register {y, tag}.
REQ-016 Set A: sum = max - (max>>3) + (min>>1); y = (sum > max) ? sum : max.
REQ-017 Set B: sum = max - (max>>4) + (min>>1) - (min>>5); y = (sum > max) ? sum : max.
REQ-018 Shifts truncate; all arithmetic SHALL be WIDTH+1 bits unsigned; no wrap occurs for any input.
REQ-019 Each stage holds a valid bit and SHALL load when it is empty or when its content moves on in the same cycle; bubbles collapse.
REQ-020 in_ready = !S1_valid | S1 advances; this is combinational from y_ready through the stage chain.
REQ-021 With y_ready held at 1, latency SHALL be 3 cycles from input transfer to y_valid, at a throughput of 1 sample per cycle.
REQ-022 With y_ready=0, the pipeline SHALL fill to 3 samples and then deassert in_ready; no sample is lost or duplicated.
REQ-023 y, y_tag and y_valid SHALL stay stable while y_valid=1 and y_ready=0.
REQ-024 Output order SHALL equal input order; the tag and mode stay bound to their own sample.
REQ-025 a == b SHALL yield max = min = a.

Reset
REQ-026 reset SHALL clear all stage valid bits asynchronously, giving y_valid=0 and in_ready=1 after release.
REQ-027 Data and tag registers are not reset; y reads as don't-care while y_valid=0.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight samples; there is no partial output.

Configuration
REQ-029 Macro MAG_APPROX_MODE_B_EN defined: in_mode selects set A or set B per sample.
REQ-030 Macro not defined: set B logic is absent, in_mode is ignored, and every sample uses set A.

Structure
REQ-031 Package mag_approx_pkg SHALL hold the mode enum (MODE_A, MODE_B) and the shift constants (SH_A_MAX=3, SH_B_MAX=4, SH_MIN=1, SH_B_MIN2=5).
REQ-032 Sub-module mag_approx_coef SHALL be combinational: (max, min, mode) -> sum, instantiated once between S1 and S2.

Verification
REQ-033 a=3, b=4, set A, y_ready=1 -> y=5 exactly 3 cycles later; set B -> y=5.
REQ-034 a=1000, b=0, set A -> sum=875, floored to y=1000; a=b=1000 -> set A y=1375, set B y=1407 (B only with the macro defined).
REQ-035 WIDTH=8, a=b=255, set A -> y=351 (9 bits), no overflow.
REQ-036 4 back-to-back samples with tags 1..4, y_ready=0 for 6 cycles and then 1 -> in_ready low after 3 accepts; outputs arrive with tags 1,2,3,4 in order, each held stable while stalled.
REQ-037 reset pulsed with 2 samples in flight -> y_valid=0 immediately; after release in_ready=1 and neither sample appears.
REQ-038 Random traffic of 1000 samples with random in_valid/y_ready -> every output matches a reference model for its tag and mode.
